// File: rtl/avg_pkg.sv
// Shared types and constants for the moving-average host sequencer.
package avg_pkg;

    localparam int AVG_WINDOW = 12;
    localparam int DEF_DW     = 16;
    localparam int DEF_AW     = 6;
    localparam int DEF_NSAMP  = 64;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRIME  = 3'd1,
        STREAM = 3'd2,
        FLUSH  = 3'd3,
        DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/avg_host_if.sv
// Host-side bus bundle: sample ROM read port, averager link and result RAM write port.
interface avg_host_if
    import avg_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int AW = DEF_AW
);
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_q;
    logic          avg_rst;
    logic [DW-1:0] avg_din;
    logic          avg_ready;
    logic [DW-1:0] avg_dout;
    logic          res_wr;
    logic [AW-1:0] res_addr;
    logic [DW-1:0] res_data;

    modport master (
        output rom_addr,
        input  rom_q,
        output avg_rst,
        output avg_din,
        input  avg_ready,
        input  avg_dout,
        output res_wr,
        output res_addr,
        output res_data
    );

    modport slave (
        input  rom_addr,
        output rom_q,
        input  avg_rst,
        input  avg_din,
        output avg_ready,
        output avg_dout,
        input  res_wr,
        input  res_addr,
        input  res_data
    );

endinterface

// File: rtl/avg_host.sv
// Sequencer that streams NSAMP ROM samples into the averager and stores its results.
module avg_host
    import avg_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int AW    = DEF_AW,
    parameter int NSAMP = DEF_NSAMP
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    avg_host_if.master    bus,
    output logic [AW:0]   res_count,
    output logic          busy,
    output logic          done
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NSAMP - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] rom_addr_q, rom_addr_d;
    logic          avg_rst_q, avg_rst_d;
    logic [AW:0]   res_count_q, res_count_d;
    logic [AW-1:0] k_q, k_d;
    logic          capture_s;
    logic [AW-1:0] rom_addr_inc_s;

    // Capture window: every STREAM cycle except the first, plus the FLUSH cycle
    always_comb begin
        capture_s = 1'b0;
        if (state_q == FLUSH) begin
            capture_s = bus.avg_ready;
        end else if ((state_q == STREAM) && (k_q != {AW{1'b0}})) begin
            capture_s = bus.avg_ready;
        end else begin
            capture_s = 1'b0;
        end
    end

    assign rom_addr_inc_s = (rom_addr_q == LAST_IDX) ? rom_addr_q : (rom_addr_q + {{(AW-1){1'b0}}, 1'b1});

    // Next-state, ROM address, averager reset and result counter
    always_comb begin
        state_d     = state_q;
        rom_addr_d  = rom_addr_q;
        avg_rst_d   = avg_rst_q;
        res_count_d = res_count_q;
        k_d         = k_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = PRIME;
                    rom_addr_d  = {AW{1'b0}};
                    avg_rst_d   = 1'b1;
                    res_count_d = {(AW+1){1'b0}};
                    k_d         = {AW{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            PRIME: begin
                avg_rst_d  = 1'b0;
                rom_addr_d = rom_addr_inc_s;
                k_d        = {AW{1'b0}};
                state_d    = STREAM;
            end
            STREAM: begin
                rom_addr_d = rom_addr_inc_s;
                if (capture_s) begin
                    res_count_d = res_count_q + {{AW{1'b0}}, 1'b1};
                end else begin
                    res_count_d = res_count_q;
                end
                if (k_q == LAST_IDX) begin
                    state_d = FLUSH;
                end else begin
                    k_d = k_q + {{(AW-1){1'b0}}, 1'b1};
                end
            end
            FLUSH: begin
                if (capture_s) begin
                    res_count_d = res_count_q + {{AW{1'b0}}, 1'b1};
                end else begin
                    res_count_d = res_count_q;
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and counter registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rom_addr_q  <= {AW{1'b0}};
            avg_rst_q   <= 1'b0;
            res_count_q <= {(AW+1){1'b0}};
            k_q         <= {AW{1'b0}};
        end else begin
            state_q     <= state_d;
            rom_addr_q  <= rom_addr_d;
            avg_rst_q   <= avg_rst_d;
            res_count_q <= res_count_d;
            k_q         <= k_d;
        end
    end

    assign bus.rom_addr = rom_addr_q;
    assign bus.avg_rst  = avg_rst_q;
    assign bus.avg_din  = (state_q == STREAM) ? bus.rom_q : {DW{1'b0}};
    assign bus.res_wr   = capture_s;
    assign bus.res_addr = capture_s ? res_count_q[AW-1:0] : {AW{1'b0}};
    assign bus.res_data = capture_s ? bus.avg_dout : {DW{1'b0}};

    assign res_count = res_count_q;
    assign busy      = (state_q == PRIME) || (state_q == STREAM) || (state_q == FLUSH);
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_avg_host.sv
// Self-checking bench: three host instances (NSAMP 16/24/1) with behavioural ROM, RAM and averagers.
module tb_avg_host;
    import avg_pkg::*;

    localparam int DW = 16;
    localparam int AW = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic start_v [3];
    int   mode [3];   // 0: stub ready after 11 samples, 1: 12-tap averager, 2: always ready
    logic [DW-1:0] rom_mem [3][64];
    logic [DW-1:0] ram     [3][64];

    logic [AW-1:0] rom_addr_w  [3];
    logic          avg_rst_w   [3];
    logic [DW-1:0] avg_din_w   [3];
    logic          res_wr_w    [3];
    logic [AW-1:0] res_addr_w  [3];
    logic [DW-1:0] res_data_w  [3];
    logic [AW:0]   res_count_w [3];
    logic          busy_w      [3];
    logic          done_w      [3];

    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int NS = (g == 0) ? 16 : ((g == 1) ? 24 : 1);
        avg_host_if #(.DW(DW), .AW(AW)) bus ();

        avg_host #(.DW(DW), .AW(AW), .NSAMP(NS)) dut (
            .clk       (clk),
            .reset     (reset),
            .start     (start_v[g]),
            .bus       (bus),
            .res_count (res_count_w[g]),
            .busy      (busy_w[g]),
            .done      (done_w[g])
        );

        logic [7:0]    scnt = 8'd0;
        logic [DW-1:0] din_q = '0;
        logic          rready = 1'b0;
        logic [DW-1:0] rdout = '0;
        logic [DW-1:0] win [12];
        int            rsum = 0;
        int            rcnt = 0;

        always @(posedge clk) bus.rom_q <= rom_mem[g][bus.rom_addr];
        always @(posedge clk) if (bus.res_wr) ram[g][bus.res_addr] <= bus.res_data;

        always @(posedge clk) begin
            din_q <= bus.avg_din;
            if (bus.avg_rst) begin
                scnt   <= 8'd0;
                rcnt   <= 0;
                rsum   <= 0;
                rready <= 1'b0;
                rdout  <= '0;
                for (int i = 0; i < 12; i++) win[i] <= '0;
            end else begin
                if (scnt != 8'd255) scnt <= scnt + 8'd1;
                win[0] <= bus.avg_din;
                for (int i = 1; i < 12; i++) win[i] <= win[i-1];
                rsum   <= rsum + int'(bus.avg_din) - int'(win[11]);
                rcnt   <= (rcnt < 12) ? rcnt + 1 : rcnt;
                rready <= (rcnt + 1) >= 12;
                rdout  <= DW'((rsum + int'(bus.avg_din) - int'(win[11])) / 12);
            end
        end

        assign bus.avg_ready = (mode[g] == 0) ? (scnt >= 8'd11) : ((mode[g] == 1) ? rready : 1'b1);
        assign bus.avg_dout  = (mode[g] == 1) ? rdout : din_q;

        assign rom_addr_w[g] = bus.rom_addr;
        assign avg_rst_w[g]  = bus.avg_rst;
        assign avg_din_w[g]  = bus.avg_din;
        assign res_wr_w[g]   = bus.res_wr;
        assign res_addr_w[g] = bus.res_addr;
        assign res_data_w[g] = bus.res_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input int g, input string tag);
        check({tag, "_busy"},     32'(busy_w[g]), 32'd0);
        check({tag, "_done"},     32'(done_w[g]), 32'd0);
        check({tag, "_avg_rst"},  32'(avg_rst_w[g]), 32'd0);
        check({tag, "_rom_addr"}, 32'(rom_addr_w[g]), 32'd0);
        check({tag, "_avg_din"},  32'(avg_din_w[g]), 32'd0);
        check({tag, "_res_wr"},   32'(res_wr_w[g]), 32'd0);
        check({tag, "_res_addr"}, 32'(res_addr_w[g]), 32'd0);
        check({tag, "_res_data"}, 32'(res_data_w[g]), 32'd0);
    endtask

    // One run: expected writes come from the averager's window rule applied to the ROM contents
    task automatic run(input int g, input int n, input int abort_k, input bit extra_starts);
        int exp_q[$];
        bit exp_pos [65];
        int nwr = 0;
        for (int p = 0; p < 65; p++) exp_pos[p] = 1'b0;
        for (int p = 1; p <= n; p++) begin
            if (mode[g] == 0) begin
                if (p >= 11) begin exp_pos[p] = 1'b1; exp_q.push_back(int'(rom_mem[g][p-1])); end
            end else if (mode[g] == 1) begin
                if (p >= 12) begin
                    int s = 0;
                    for (int j = p - 12; j < p; j++) s += int'(rom_mem[g][j]);
                    exp_pos[p] = 1'b1;
                    exp_q.push_back(s / 12);
                end
            end else begin
                exp_pos[p] = 1'b1;
                exp_q.push_back(int'(rom_mem[g][p-1]));
            end
        end

        start_v[g] = 1'b1;
        tick();
        start_v[g] = 1'b0;
        check($sformatf("i%0d_prime_avg_rst", g), 32'(avg_rst_w[g]), 32'd1);
        check($sformatf("i%0d_prime_busy", g), 32'(busy_w[g]), 32'd1);
        check($sformatf("i%0d_prime_rom_addr", g), 32'(rom_addr_w[g]), 32'd0);
        check($sformatf("i%0d_prime_res_wr", g), 32'(res_wr_w[g]), 32'd0);
        check($sformatf("i%0d_prime_res_count", g), 32'(res_count_w[g]), 32'd0);

        for (int k = 0; k < n; k++) begin
            tick();
            start_v[g] = 1'b0;
            check($sformatf("i%0d_k%0d_avg_din", g, k), 32'(avg_din_w[g]), 32'(rom_mem[g][k]));
            check($sformatf("i%0d_k%0d_rom_addr", g, k), 32'(rom_addr_w[g]), 32'((k + 1 < n) ? k + 1 : n - 1));
            check($sformatf("i%0d_k%0d_avg_rst", g, k), 32'(avg_rst_w[g]), 32'd0);
            check($sformatf("i%0d_k%0d_busy", g, k), 32'(busy_w[g]), 32'd1);
            check($sformatf("i%0d_k%0d_done", g, k), 32'(done_w[g]), 32'd0);
            check($sformatf("i%0d_k%0d_res_wr", g, k), 32'(res_wr_w[g]), 32'(exp_pos[k]));
            if (res_wr_w[g] && exp_pos[k]) begin
                check($sformatf("i%0d_k%0d_res_addr", g, k), 32'(res_addr_w[g]), 32'(nwr));
                check($sformatf("i%0d_k%0d_res_data", g, k), 32'(res_data_w[g]), 32'(exp_q[nwr]));
                nwr++;
            end
            if (k == abort_k) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                check_quiet(g, $sformatf("i%0d_abort", g));
                check($sformatf("i%0d_abort_res_count", g), 32'(res_count_w[g]), 32'd0);
                for (int c = 0; c < n + 4; c++) begin
                    tick();
                    check($sformatf("i%0d_abort_c%0d_done", g, c), 32'(done_w[g]), 32'd0);
                    check($sformatf("i%0d_abort_c%0d_res_wr", g, c), 32'(res_wr_w[g]), 32'd0);
                end
                return;
            end
            if (extra_starts && (k == n / 2)) start_v[g] = 1'b1;
        end

        tick();
        start_v[g] = 1'b0;
        check($sformatf("i%0d_flush_avg_din", g), 32'(avg_din_w[g]), 32'd0);
        check($sformatf("i%0d_flush_busy", g), 32'(busy_w[g]), 32'd1);
        check($sformatf("i%0d_flush_done", g), 32'(done_w[g]), 32'd0);
        check($sformatf("i%0d_flush_res_wr", g), 32'(res_wr_w[g]), 32'(exp_pos[n]));
        if (res_wr_w[g] && exp_pos[n]) begin
            check($sformatf("i%0d_flush_res_addr", g), 32'(res_addr_w[g]), 32'(nwr));
            check($sformatf("i%0d_flush_res_data", g), 32'(res_data_w[g]), 32'(exp_q[nwr]));
        end

        tick();
        check($sformatf("i%0d_done_pulse", g), 32'(done_w[g]), 32'd1);
        check($sformatf("i%0d_done_busy", g), 32'(busy_w[g]), 32'd0);
        check($sformatf("i%0d_done_res_wr", g), 32'(res_wr_w[g]), 32'd0);
        check($sformatf("i%0d_done_res_count", g), 32'(res_count_w[g]), 32'(exp_q.size()));
        if (extra_starts) start_v[g] = 1'b1;

        tick();
        start_v[g] = 1'b0;
        check($sformatf("i%0d_post_done", g), 32'(done_w[g]), 32'd0);
        check($sformatf("i%0d_post_busy", g), 32'(busy_w[g]), 32'd0);
        check($sformatf("i%0d_post_avg_rst", g), 32'(avg_rst_w[g]), 32'd0);
        check($sformatf("i%0d_post_res_count", g), 32'(res_count_w[g]), 32'(exp_q.size()));
        tick();
        check($sformatf("i%0d_post2_busy", g), 32'(busy_w[g]), 32'd0);
        check($sformatf("i%0d_post2_done", g), 32'(done_w[g]), 32'd0);
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("i%0d_ram%0d", g, i), 32'(ram[g][i]), 32'(exp_q[i]));
    endtask

    initial begin
        reset = 1'b1;
        for (int g = 0; g < 3; g++) begin
            start_v[g] = 1'b0;
            mode[g] = 0;
            for (int i = 0; i < 64; i++) rom_mem[g][i] = '0;
        end

        // Reset then idle
        repeat (3) tick();
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            check($sformatf("idle_c%0d_busy", c), 32'(busy_w[0]), 32'd0);
            check($sformatf("idle_c%0d_res_wr", c), 32'(res_wr_w[0]), 32'd0);
        end
        for (int g = 0; g < 3; g++) begin
            check_quiet(g, $sformatf("i%0d_idle", g));
            check($sformatf("i%0d_idle_res_count", g), 32'(res_count_w[g]), 32'd0);
        end

        // start in the same cycle as reset is ignored
        reset = 1'b1;
        start_v[0] = 1'b1;
        tick();
        reset = 1'b0;
        start_v[0] = 1'b0;
        check("rst_start_busy", 32'(busy_w[0]), 32'd0);
        check("rst_start_avg_rst", 32'(avg_rst_w[0]), 32'd0);
        tick();
        check("rst_start_busy2", 32'(busy_w[0]), 32'd0);

        // NSAMP=16 ramp with stub averager
        for (int i = 0; i < 64; i++) rom_mem[0][i] = DW'(i);
        mode[0] = 0;
        run(0, 16, -1, 1'b0);

        // NSAMP=24 constant samples through the 12-tap averager
        for (int i = 0; i < 64; i++) rom_mem[1][i] = 16'h1234;
        mode[1] = 1;
        run(1, 24, -1, 1'b0);

        // NSAMP=1 with stub averager: no results
        for (int i = 0; i < 64; i++) rom_mem[2][i] = DW'($urandom);
        mode[2] = 0;
        run(2, 1, -1, 1'b0);

        // Random samples, extra start pulses in STREAM and on DONE
        for (int i = 0; i < 64; i++) rom_mem[0][i] = DW'($urandom);
        run(0, 16, -1, 1'b1);

        // Abort at k=5, then a clean always-ready run (first STREAM cycle suppressed)
        mode[0] = 2;
        for (int i = 0; i < 64; i++) rom_mem[0][i] = DW'($urandom);
        run(0, 16, 5, 1'b0);
        run(0, 16, -1, 1'b0);

        // Random samples through the 12-tap averager
        for (int i = 0; i < 64; i++) rom_mem[1][i] = DW'($urandom);
        run(1, 24, -1, 1'b0);

        // NSAMP=1 always ready: only the FLUSH cycle writes
        mode[2] = 2;
        for (int i = 0; i < 64; i++) rom_mem[2][i] = DW'($urandom);
        run(2, 1, -1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
